// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined add/subtract unit.
// ADDSUB_SAT_EN adds the sat flag to the per-stage control payload.
package alu_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Widest result sat_value can produce.
    localparam int SAT_MAX_W = 256;

    // Control half of the stage payload; operand/sum bits are sized per stage in the pipe.
    typedef struct packed {
        logic valid;
        logic carry;
`ifdef ADDSUB_SAT_EN
        logic sub;
        logic sat;
`endif
    } stage_ctrl_t;

    // Saturation limit for a width-bit two's-complement result.
    // sign = 0 gives the most positive value, sign = 1 the most negative.
    function automatic logic [SAT_MAX_W-1:0] sat_value(input logic sign, input int width);
        logic [SAT_MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < SAT_MAX_W; i++) begin
            if (i < width) begin
                v[i] = (i == width - 1) ? sign : ~sign;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/alu_addsub_slice.sv
// Combinational CHUNK-bit ripple adder built from fulladder cells.
// cmsb is the carry into the slice MSB, needed for the signed-overflow flag.
module alu_addsub_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        fulladder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    assign cout = c[CHUNK];
    assign cmsb = c[CHUNK-1];

endmodule

// File: rtl/fulladder.sv
// One-bit full adder cell from the alu32 datapath.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/alu_addsub_pipe.sv
// Pipelined WIDTH-bit add/subtract: the ripple carry chain is cut into STAGES registered slices.
// Optional build macro ADDSUB_SAT_EN adds a sat input that clamps overflowing results.
module alu_addsub_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic             sub,
`ifdef ADDSUB_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int CHUNK = WIDTH / STAGES;

    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_param_check
        $error("alu_addsub_pipe: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
    end

    // Whole pipe moves as one: any stall freezes every stage, bubbles included.
    logic adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits not yet consumed shrink by CHUNK per stage; finished sum bits grow.
        localparam int RW = WIDTH - k * CHUNK;

        logic [RW-1:0]          a_i;
        logic [RW-1:0]          b_i;
        stage_ctrl_t            ctrl_i;
        logic [(k+1)*CHUNK-1:0] s_done;
        logic [CHUNK-1:0]       s_slice;
        logic                   c_slice;
        logic                   c_msb;

        if (k == 0) begin : g_src
            logic is_sub;

            assign is_sub = (sub == OP_SUB);
            assign a_i    = input1;
            assign b_i    = input2 ^ {WIDTH{is_sub}};
            assign s_done = s_slice;

            always_comb begin
                ctrl_i       = '0;
                ctrl_i.valid = in_valid;
                ctrl_i.carry = is_sub;
`ifdef ADDSUB_SAT_EN
                ctrl_i.sub   = sub;
                ctrl_i.sat   = sat;
`endif
            end
        end else begin : g_src
            assign a_i    = g_stage[k-1].g_reg.a_p;
            assign b_i    = g_stage[k-1].g_reg.b_p;
            assign ctrl_i = g_stage[k-1].g_reg.ctrl_p;
            assign s_done = {s_slice, g_stage[k-1].g_reg.s_p};
        end

        alu_addsub_slice #(
            .CHUNK (CHUNK)
        ) u_slice (
            .a    (a_i[CHUNK-1:0]),
            .b    (b_i[CHUNK-1:0]),
            .cin  (ctrl_i.carry),
            .s    (s_slice),
            .cout (c_slice),
            .cmsb (c_msb)
        );

        if (k < STAGES - 1) begin : g_reg
            logic [RW-CHUNK-1:0]    a_p;
            logic [RW-CHUNK-1:0]    b_p;
            logic [(k+1)*CHUNK-1:0] s_p;
            stage_ctrl_t            ctrl_p;
            logic                   c_msb_unused;

            assign c_msb_unused = c_msb;

            // ---- stage k -> k+1 boundary ----
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ctrl_p <= '0;
                end else if (adv) begin
                    ctrl_p       <= ctrl_i;
                    ctrl_p.carry <= c_slice;
                end
            end

            always_ff @(posedge clk) begin
                if (adv) begin
                    a_p <= a_i[RW-1:CHUNK];
                    b_p <= b_i[RW-1:CHUNK];
                    s_p <= s_done;
                end
            end
        end else begin : g_out
            logic [WIDTH-1:0] res;
            logic             ovf;

            assign ovf = c_msb ^ c_slice;

`ifdef ADDSUB_SAT_EN
            // On overflow both operand signs agree, so either one names the clamp direction.
            logic sign;

            assign sign = (ctrl_i.sub == OP_ADD) ? a_i[CHUNK-1] : b_i[CHUNK-1];
            assign res  = (ctrl_i.sat && ovf) ? WIDTH'(sat_value(sign, WIDTH)) : s_done;
`else
            assign res = s_done;
`endif

            // ---- output register boundary ----
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_valid <= 1'b0;
                    sum       <= '0;
                    carry_out <= 1'b0;
                    overflow  <= 1'b0;
                    zero      <= 1'b0;
                end else if (adv) begin
                    out_valid <= ctrl_i.valid;
                    sum       <= res;
                    carry_out <= c_slice;
                    overflow  <= ovf;
                    zero      <= ~|res;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_addsub_pipe.sv
// Scoreboard bench for alu_addsub_pipe: corner operations, back-to-back stream with stall,
// asynchronous reset with work in flight, and a long random run against an arithmetic model.
module tb_alu_addsub_pipe;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;
`ifdef ADDSUB_SAT_EN
    localparam bit SAT_BUILD = 1'b1;
`else
    localparam bit SAT_BUILD = 1'b0;
`endif
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONES    = {WIDTH{1'b1}};
    localparam int RAND_OPS = 10000;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] input1;
    logic [WIDTH-1:0] input2;
    logic             sub;
    logic             sat_i;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             c;
        logic             v;
        logic             z;
        int               t;
    } exp_t;

    exp_t exp_q[$];
    int   cyc     = 0;
    int   n_cmp   = 0;
    int   n_bad   = 0;
    bit   lat_chk = 1'b0;

    alu_addsub_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .input1    (input1),
        .input2    (input2),
        .sub       (sub),
`ifdef ADDSUB_SAT_EN
        .sat       (sat_i),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d results still pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    // Reference: plain modular arithmetic, unsigned compare for borrow, sign rules for overflow.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic s, input logic st);
        exp_t           e;
        logic [WIDTH:0] wide;
        logic           sign;
        if (!s) begin
            wide = {1'b0, a} + {1'b0, b};
            e.c  = wide[WIDTH];
        end else begin
            wide = {1'b0, a} - {1'b0, b};
            e.c  = (a >= b);
        end
        e.sum = wide[WIDTH-1:0];
        if (!s) e.v = (a[WIDTH-1] == b[WIDTH-1]) && (e.sum[WIDTH-1] != a[WIDTH-1]);
        else    e.v = (a[WIDTH-1] != b[WIDTH-1]) && (e.sum[WIDTH-1] != a[WIDTH-1]);
        if (SAT_BUILD && st && e.v) begin
            sign  = s ? ~b[WIDTH-1] : a[WIDTH-1];
            e.sum = sign ? MIN_NEG : MAX_POS;
        end
        e.z = (e.sum == '0);
        e.t = cyc;
        return e;
    endfunction

    task automatic check_w(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every consumed output is matched against the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got sum=%h with no operation pending, expected none", sum);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                n_cmp++;
                if ({sum, carry_out, overflow, zero} !== {e.sum, e.c, e.v, e.z}) begin
                    n_bad++;
                    $display("FAIL result: got sum=%h c=%b v=%b z=%b expected sum=%h c=%b v=%b z=%b",
                             sum, carry_out, overflow, zero, e.sum, e.c, e.v, e.z);
                end
                if (lat_chk) check_i("latency", cyc - e.t, STAGES);
            end
        end
    end

    // One cycle of stimulus; an accepted operation queues its expected result.
    task automatic drive(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic s, input logic st, input logic ordy, output bit acc);
        @(posedge clk);
        #1;
        in_valid  = v;
        input1    = a;
        input2    = b;
        sub       = s;
        sat_i     = st;
        out_ready = ordy;
        @(negedge clk);
        acc = in_valid && in_ready;
        if (acc) exp_q.push_back(model(a, b, s, st));
        #1;
    endtask

    task automatic drain();
        bit acc;
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20 * STAGES + 50) begin
            drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
            n++;
        end
        check_i("drain_pending", exp_q.size(), 0);
    endtask

    function automatic logic [WIDTH-1:0] rand_op();
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < (WIDTH + 31) / 32; i++) r = (r << 32) | WIDTH'($urandom);
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return ONES;
            2:       return MAX_POS;
            3:       return MIN_NEG;
            4:       return WIDTH'(1);
            default: return r;
        endcase
    endfunction

    initial begin
        bit acc;
        int acc_n;
        int budget;

        rst       = 1'b1;
        in_valid  = 1'b0;
        input1    = '0;
        input2    = '0;
        sub       = 1'b0;
        sat_i     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_b("reset_out_valid", out_valid, 1'b0);
        check_w("reset_sum", sum, '0);
        check_b("reset_carry", carry_out, 1'b0);
        check_b("reset_overflow", overflow, 1'b0);
        check_b("reset_zero", zero, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_b("in_ready_after_reset", in_ready, 1'b1);

        // Corner operations with the consumer always ready: exact latency is checked too.
        lat_chk = 1'b1;
        drive(1'b1, MAX_POS, WIDTH'(1), 1'b0, 1'b0, 1'b1, acc);
        drive(1'b1, WIDTH'(5), WIDTH'(5), 1'b1, 1'b0, 1'b1, acc);
        drive(1'b1, '0, WIDTH'(1), 1'b1, 1'b0, 1'b1, acc);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
        drive(1'b1, MAX_POS, WIDTH'(1), 1'b0, 1'b1, 1'b1, acc);
        drive(1'b1, MIN_NEG, WIDTH'(1), 1'b1, 1'b1, 1'b1, acc);
        drive(1'b1, MIN_NEG, WIDTH'(1), 1'b1, 1'b0, 1'b1, acc);
        drive(1'b1, MIN_NEG, MIN_NEG, 1'b0, 1'b1, 1'b1, acc);
        drive(1'b1, ONES, ONES, 1'b0, 1'b0, 1'b1, acc);
        drain();

        // Back-to-back stream, then a three-cycle consumer stall mid-stream.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, rand_op(), rand_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, acc);
            check_b("b2b_accept", acc, 1'b1);
        end
        lat_chk = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, rand_op(), rand_op(), 1'b0, 1'b0, 1'b0, acc);
            check_b("stall_in_ready", in_ready, 1'b0);
            check_b("stall_out_valid", out_valid, 1'b1);
            if (exp_q.size() != 0) check_w("stall_sum_held", sum, exp_q[0].sum);
            else check_i("stall_pending", exp_q.size(), 1);
        end
        drain();

        // Asynchronous reset with operations in flight and a result waiting at the output.
        for (int i = 0; i < 3; i++) drive(1'b1, MAX_POS, MAX_POS, 1'b0, 1'b0, 1'b0, acc);
        for (int i = 0; i < STAGES; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc);
        check_b("pre_reset_out_valid", out_valid, 1'b1);
        check_b("pre_reset_overflow", overflow, 1'b1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_b("async_reset_out_valid", out_valid, 1'b0);
        check_w("async_reset_sum", sum, '0);
        check_b("async_reset_overflow", overflow, 1'b0);
        check_b("async_reset_carry", carry_out, 1'b0);
        check_b("async_reset_zero", zero, 1'b0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 2 * STAGES + 2; i++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
            check_b("post_reset_idle", out_valid, 1'b0);
        end

        // Random traffic with random producer gaps and consumer back-pressure.
        acc_n  = 0;
        budget = 0;
        while (acc_n < RAND_OPS && budget < 40000) begin
            drive(1'($urandom_range(0, 3) != 0), rand_op(), rand_op(), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), acc);
            acc_n += int'(acc);
            budget++;
        end
        check_i("random_ops_accepted", acc_n, RAND_OPS);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
